preload_sequencer: RTL and testbench
====================================

# preload_sequencer

Top-level controller for the pre-load unit. It accepts one job: a start pulse followed by a byte stream of 64 weights, then 64 activations. It writes the stream into the weight and activation memories with sequential addresses. It then drives the load_mem_done, PreLoad_CWeight and Cal phase signals, in order, to run the compensation array for one tile, and reports busy/done to the host.

## Interface
Parameters:
- W_DEPTH, 64, number of weight beats per job; the address counter is 6 bits.
- A_DEPTH, 64, number of activation beats per job.
- CW_CYCLES, 3, cycles PreLoad_CWeight is held high (one per CPE in a 3-deep column).
- CAL_CYCLES, 22, cycles Cal is held high (8 rows + 8 columns + 3 CPEs + 3 drain).

Ports:
- clk, in, 1, sole clock; all state updates on its rising edge.
- rst, in, 1, reset; asynchronous, active-low.
- start, in, 1, begins a job; sampled only in IDLE.
- abort, in, 1, synchronous cancel; return to IDLE.
- in_valid, in, 1, a stream beat is present.
- in_ready, out, 1, sequencer accepts a beat; high only in LOAD_W and LOAD_A.
- in_data, in, 8, beat payload.
- Weight, out, 8, weight memory write data.
- Weight_Mem_Address_in, out, 6, weight memory address.
- weight_we, out, 1, one-cycle write strobe for the weight memory.
- Activation, out, 7, activation memory write data; equals in_data[6:0].
- Activation_Mem_Address_in, out, 6, activation memory address.
- act_we, out, 1, one-cycle write strobe for the activation memory.
- load_mem_done, out, 1, both memories are loaded (level).
- PreLoad_CWeight, out, 1, compensation-weight preload phase.
- Cal, out, 1, compute phase.
- busy, out, 1, state is not IDLE.
- done, out, 1, one-cycle pulse at the end of a job.

## Operation
- States: IDLE, LOAD_W, LOAD_A, LOAD_END, PRE_CW, CALC, FIN.
- IDLE -> LOAD_W on start. Otherwise remain in IDLE.
- A beat is accepted when in_valid && in_ready.
- In LOAD_W, each accepted beat registers Weight=in_data and Weight_Mem_Address_in=cnt, pulses weight_we, then increments cnt. When the beat with cnt==W_DEPTH-1 is accepted: clear cnt and go to LOAD_A.
- In LOAD_A, the same rules apply to Activation, Activation_Mem_Address_in and act_we. The final beat goes to LOAD_END.
- LOAD_END lasts one cycle, in which load_mem_done rises; then go to PRE_CW.
- PRE_CW: PreLoad_CWeight=1 for exactly CW_CYCLES cycles; then go to CALC.
- CALC: Cal=1 for exactly CAL_CYCLES cycles; then go to FIN.
- FIN: done=1 for one cycle; then go to IDLE.
- load_mem_done stays high from LOAD_END through FIN and clears on entry to IDLE.
- Data and address outputs hold their last value when no beat is accepted.
- PreLoad_CWeight and Cal are never high together. Cal is never high while load_mem_done is low.
- A single phase counter (width clog2 of max(W_DEPTH, A_DEPTH, CW_CYCLES, CAL_CYCLES)) is reused across phases and cleared on every state change.

## Timing
- Reset (rst low, asynchronous): state=IDLE, cnt=0. Every output is 0, including the data/address outputs and in_ready.
- start at cycle t → busy=1 and in_ready=1 at t+1.
- Beat accepted at cycle k → data, address and _we are visible at k+1. There is no backpressure stall; throughput is one beat per cycle.
- in_valid=0 mid-load: cnt holds and the _we strobe is 0.
- Final activation beat at cycle k → load_mem_done=1 at k+1 (LOAD_END) and at k+2 (first PRE_CW cycle); PreLoad_CWeight=1 from k+2 to k+1+CW_CYCLES.
- With the defaults, the minimum job takes 1 + 64 + 64 + 1 + 3 + 22 + 1 cycles from start.
- start while busy: ignored.
- start and abort in the same cycle in IDLE: abort wins; stay in IDLE.
- abort in any state: the next cycle is IDLE with all outputs 0, cnt=0 and no done pulse.
- in_valid while in_ready=0: ignored; the beat is not consumed.
- rst asserted mid-job: immediate return to the reset values; no partial done.

## Structure
- A shared package (pre_load_pkg) holds:
  - the state enum;
  - the address width (6);
  - the weight width (8) and activation width (7);
  - the default phase lengths.
- Sub-module phase_counter: a loadable down-counter with a terminal-count flag, reused for each phase length. The FSM and output registers stay in preload_sequencer.

## Test plan
- Reset mid-CALC → all outputs are 0 immediately; busy=0.
- Full job with continuous in_valid and data = address index:
  - weight_we fires 64 times with Weight 0..63 at addresses 0..63;
  - act_we fires 64 times with Activation 0..63;
  - load_mem_done rises 1 cycle after the last activation beat;
  - PreLoad_CWeight is high for 3 cycles, then Cal is high for 22 cycles;
  - done pulses once.
- in_valid toggling 1/0 during LOAD_W → 64 writes with no skipped or duplicated address; LOAD_A begins only after the 64th weight beat.
- abort at weight beat 30 → IDLE next cycle; a new start restarts at Weight_Mem_Address_in=0.
- start pulsed during CALC → no effect; the job completes with a single done pulse.
- in_valid=1 in IDLE and PRE_CW → in_ready=0, no _we strobes, and cnt unchanged.

Source files
------------

// File: rtl/pre_load_pkg.sv
// Shared types and constants for the pre-load sequencer: FSM states,
// memory data/address widths and the default phase lengths.
package pre_load_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_A,
        LOAD_END,
        PRE_CW,
        CALC,
        FIN
    } state_t;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 8;
    localparam int WEIGHT_W = 8;
    localparam int ACT_W    = 7;

    localparam int DEF_W_DEPTH    = 64;
    localparam int DEF_A_DEPTH    = 64;
    localparam int DEF_CW_CYCLES  = 3;
    localparam int DEF_CAL_CYCLES = 22;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter with a terminal-count flag; one instance is reused
// for every phase length of the sequencer.
module phase_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/preload_sequencer.sv
// Pre-load unit controller: streams 64 weights then 64 activations into their
// memories, then sequences load_mem_done, PreLoad_CWeight and Cal for one tile.
module preload_sequencer
    import pre_load_pkg::*;
#(
    parameter int W_DEPTH    = DEF_W_DEPTH,
    parameter int A_DEPTH    = DEF_A_DEPTH,
    parameter int CW_CYCLES  = DEF_CW_CYCLES,
    parameter int CAL_CYCLES = DEF_CAL_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic [WEIGHT_W-1:0] Weight,
    output logic [ADDR_W-1:0]   Weight_Mem_Address_in,
    output logic                weight_we,
    output logic [ACT_W-1:0]    Activation,
    output logic [ADDR_W-1:0]   Activation_Mem_Address_in,
    output logic                act_we,
    output logic                load_mem_done,
    output logic                PreLoad_CWeight,
    output logic                Cal,
    output logic                busy,
    output logic                done
);

    localparam int MAX_LEN = max_int(max_int(W_DEPTH, A_DEPTH),
                                     max_int(CW_CYCLES, CAL_CYCLES));
    localparam int CNT_W   = $clog2(MAX_LEN);

    state_t           state;
    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_load_value;
    logic [CNT_W-1:0] cnt;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] a_addr;

    assign accept = in_valid && in_ready;

    // The counter holds beats remaining, so the write address counts up from 0.
    assign w_addr = ADDR_W'(W_DEPTH - 1 - int'(cnt));
    assign a_addr = ADDR_W'(A_DEPTH - 1 - int'(cnt));

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        cnt_load_value = '0;
        if (abort) begin
            cnt_load = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt_load       = 1'b1;
                        cnt_load_value = CNT_W'(W_DEPTH - 1);
                    end
                end
                LOAD_W: begin
                    if (accept && cnt_tc) begin
                        cnt_load       = 1'b1;
                        cnt_load_value = CNT_W'(A_DEPTH - 1);
                    end else if (accept) begin
                        cnt_dec = 1'b1;
                    end
                end
                LOAD_A: begin
                    if (accept && cnt_tc) begin
                        cnt_load = 1'b1;
                    end else if (accept) begin
                        cnt_dec = 1'b1;
                    end
                end
                LOAD_END: begin
                    cnt_load       = 1'b1;
                    cnt_load_value = CNT_W'(CW_CYCLES - 1);
                end
                PRE_CW: begin
                    if (cnt_tc) begin
                        cnt_load       = 1'b1;
                        cnt_load_value = CNT_W'(CAL_CYCLES - 1);
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                CALC: begin
                    if (cnt_tc) begin
                        cnt_load = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    cnt_load = 1'b1;
                end
            endcase
        end
    end

    phase_counter #(
        .WIDTH(CNT_W)
    ) u_phase_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .load_value(cnt_load_value),
        .dec       (cnt_dec),
        .count     (cnt),
        .tc        (cnt_tc)
    );

    // NOTE: the asynchronous reset clears every output register, data and
    // address included, so nothing from a cancelled job is left visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                     <= IDLE;
            in_ready                  <= 1'b0;
            Weight                    <= '0;
            Weight_Mem_Address_in     <= '0;
            weight_we                 <= 1'b0;
            Activation                <= '0;
            Activation_Mem_Address_in <= '0;
            act_we                    <= 1'b0;
            load_mem_done             <= 1'b0;
            PreLoad_CWeight           <= 1'b0;
            Cal                       <= 1'b0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
        end else begin
            weight_we <= 1'b0;
            act_we    <= 1'b0;
            done      <= 1'b0;
            if (abort) begin
                state                     <= IDLE;
                in_ready                  <= 1'b0;
                Weight                    <= '0;
                Weight_Mem_Address_in     <= '0;
                Activation                <= '0;
                Activation_Mem_Address_in <= '0;
                load_mem_done             <= 1'b0;
                PreLoad_CWeight           <= 1'b0;
                Cal                       <= 1'b0;
                busy                      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= LOAD_W;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                    LOAD_W: begin
                        if (accept) begin
                            Weight                <= in_data;
                            Weight_Mem_Address_in <= w_addr;
                            weight_we             <= 1'b1;
                            if (cnt_tc) begin
                                state <= LOAD_A;
                            end
                        end
                    end
                    LOAD_A: begin
                        if (accept) begin
                            Activation                <= in_data[ACT_W-1:0];
                            Activation_Mem_Address_in <= a_addr;
                            act_we                    <= 1'b1;
                            if (cnt_tc) begin
                                state         <= LOAD_END;
                                in_ready      <= 1'b0;
                                load_mem_done <= 1'b1;
                            end
                        end
                    end
                    LOAD_END: begin
                        state           <= PRE_CW;
                        PreLoad_CWeight <= 1'b1;
                    end
                    PRE_CW: begin
                        if (cnt_tc) begin
                            state           <= CALC;
                            PreLoad_CWeight <= 1'b0;
                            Cal             <= 1'b1;
                        end
                    end
                    CALC: begin
                        if (cnt_tc) begin
                            state <= FIN;
                            Cal   <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    FIN: begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        load_mem_done <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_preload_sequencer.sv
// Randomized self-checking bench for preload_sequencer against a beat-count /
// post-load-cycle reference model.
module tb_preload_sequencer;

    localparam int W_DEPTH    = 64;
    localparam int A_DEPTH    = 64;
    localparam int CW_CYCLES  = 3;
    localparam int CAL_CYCLES = 22;
    localparam int POST_FIN   = 2 + CW_CYCLES + CAL_CYCLES;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic [7:0] Weight;
    logic [5:0] Weight_Mem_Address_in;
    logic       weight_we;
    logic [6:0] Activation;
    logic [5:0] Activation_Mem_Address_in;
    logic       act_we;
    logic       load_mem_done;
    logic       PreLoad_CWeight;
    logic       Cal;
    logic       busy;
    logic       done;

    preload_sequencer #(
        .W_DEPTH   (W_DEPTH),
        .A_DEPTH   (A_DEPTH),
        .CW_CYCLES (CW_CYCLES),
        .CAL_CYCLES(CAL_CYCLES)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .abort                    (abort),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .in_data                  (in_data),
        .Weight                   (Weight),
        .Weight_Mem_Address_in    (Weight_Mem_Address_in),
        .weight_we                (weight_we),
        .Activation               (Activation),
        .Activation_Mem_Address_in(Activation_Mem_Address_in),
        .act_we                   (act_we),
        .load_mem_done            (load_mem_done),
        .PreLoad_CWeight          (PreLoad_CWeight),
        .Cal                      (Cal),
        .busy                     (busy),
        .done                     (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a job is "weights seen, activations seen, cycles since
    // the last activation beat"; every output is a function of those counts.
    bit       m_busy;
    int       m_wn, m_an, m_post;
    bit       m_wwe, m_awe;
    bit [7:0] m_weight;
    bit [5:0] m_waddr;
    bit [6:0] m_act;
    bit [5:0] m_aaddr;

    int wwe_seen, awe_seen, cw_seen, cal_seen, done_seen;

    task model_reset();
        m_busy = 0; m_wn = 0; m_an = 0; m_post = 0;
        m_wwe = 0; m_awe = 0;
        m_weight = '0; m_waddr = '0; m_act = '0; m_aaddr = '0;
    endtask

    task model_step();
        m_wwe = 0;
        m_awe = 0;
        if (abort) begin
            model_reset();
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_wn = 0; m_an = 0; m_post = 0;
            end
        end else if (m_post > 0) begin
            m_post++;
            if (m_post > POST_FIN) begin
                m_busy = 0;
                m_post = 0;
            end
        end else if (in_valid) begin
            if (m_wn < W_DEPTH) begin
                m_weight = in_data;
                m_waddr  = 6'(m_wn);
                m_wn++;
                m_wwe = 1;
            end else begin
                m_act   = in_data[6:0];
                m_aaddr = 6'(m_an);
                m_an++;
                m_awe = 1;
                if (m_an == A_DEPTH) m_post = 1;
            end
        end
    endtask

    function automatic logic [7:0] exp_ctrl();
        logic rdy;
        rdy = m_busy && (m_an < A_DEPTH);
        return {rdy, m_wwe, m_awe, m_post >= 1,
                (m_post >= 2) && (m_post <= 1 + CW_CYCLES),
                (m_post >= 2 + CW_CYCLES) && (m_post <= 1 + CW_CYCLES + CAL_CYCLES),
                m_busy, m_post == POST_FIN};
    endfunction

    task automatic compare_all();
        check("ctrl", 32'({in_ready, weight_we, act_we, load_mem_done,
                           PreLoad_CWeight, Cal, busy, done}), 32'(exp_ctrl()));
        check("wr_weight", 32'({Weight_Mem_Address_in, Weight}), 32'({m_waddr, m_weight}));
        check("wr_act", 32'({Activation_Mem_Address_in, Activation}), 32'({m_aaddr, m_act}));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        wwe_seen  += int'(weight_we);
        awe_seen  += int'(act_we);
        cw_seen   += int'(PreLoad_CWeight);
        cal_seen  += int'(Cal);
        done_seen += int'(done);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start    = 1'b0;
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            cycle();
        end
        in_valid = 1'b0;
    endtask

    // vmode: 0 continuous valid, 1 valid toggling, 2 random valid and data.
    task automatic run_job(input int vmode, input int abort_wn, input bit poke_start,
                           input int rst_post, input bit rand_abort, input bit expect_full);
        wwe_seen = 0; awe_seen = 0; cw_seen = 0; cal_seen = 0; done_seen = 0;
        start = 1'b1;
        in_valid = 1'b0;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 3000 && m_busy; i++) begin
            if (rst_post > 0 && m_post == rst_post) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                compare_all();
                check("rst_mid_busy", 32'(busy), 32'(0));
                #2 rst = 1'b1;
                break;
            end
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (i % 2) == 0;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (vmode == 2) in_data = 8'($urandom);
            else            in_data = (m_wn < W_DEPTH) ? 8'(m_wn) : 8'(m_an);
            start = poke_start && (m_post == 10);
            abort = (abort_wn >= 0 && m_post == 0 && m_an == 0 && m_wn == abort_wn) ||
                    (rand_abort && $urandom_range(0, 299) == 0);
            cycle();
        end
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        check("job_terminated", 32'(m_busy), 32'(0));
        if (expect_full) begin
            check("weight_we_count", 32'(wwe_seen), 32'(W_DEPTH));
            check("act_we_count", 32'(awe_seen), 32'(A_DEPTH));
            check("cw_cycles", 32'(cw_seen), 32'(CW_CYCLES));
            check("cal_cycles", 32'(cal_seen), 32'(CAL_CYCLES));
            check("done_pulses", 32'(done_seen), 32'(1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #12;
        compare_all();
        #5 rst = 1'b1;

        idle_cycles(4);
        run_job(0, -1, 1'b0, 0, 1'b0, 1'b1);
        idle_cycles(3);
        run_job(1, -1, 1'b0, 0, 1'b0, 1'b1);
        run_job(0, 30, 1'b0, 0, 1'b0, 1'b0);
        check("abort_no_done", 32'(done_seen), 32'(0));
        run_job(0, -1, 1'b1, 0, 1'b0, 1'b1);
        run_job(0, -1, 1'b0, 10, 1'b0, 1'b0);
        idle_cycles(2);
        run_job(0, -1, 1'b0, 0, 1'b0, 1'b1);

        // Start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'(busy), 32'(0));

        for (int j = 0; j < 8; j++) begin
            idle_cycles(int'($urandom_range(0, 5)));
            run_job(2, -1, 1'($urandom_range(0, 1)), 0, 1'b1, 1'b0);
        end

        idle_cycles(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
